// File: rtl/calc_scheduler_pkg.sv
// Shared types and constants for the calculator scheduler.
// Data width, MODO encodings and scheduler FSM states.
package calc_scheduler_pkg;

    localparam int CALC_DATA_W = 8;

    localparam logic [1:0] MODO_0 = 2'b00;
    localparam logic [1:0] MODO_1 = 2'b01;
    localparam logic [1:0] MODO_2 = 2'b10;
    localparam logic [1:0] MODO_3 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/calc_scheduler_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant.
// Ports: req[1:0], ptr (preferred on tie) -> gnt[1:0] one-hot, gnt_id.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = ptr ? 2'b10 : 2'b01;
    end

    assign gnt_id = gnt[1];

endmodule

// File: rtl/calc_scheduler.sv
// calc_scheduler: shares one Calculadora between two requesters.
// Ports: clk/rst, req_* (2 requesters, valid/ready), calc_* (calculator),
//   rsp_* (tagged response, valid/ready), op_count (saturating).
module calc_scheduler
    import calc_scheduler_pkg::*;
#(
    parameter int DATA_W   = CALC_DATA_W,
    parameter int CALC_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_modo0,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [1:0]        req_modo1,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic              calc_en,
    output logic [1:0]        calc_modo,
    output logic [DATA_W-1:0] calc_a,
    output logic [DATA_W-1:0] calc_b,
    input  logic [DATA_W-1:0] calc_c,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CNT_W-1:0]  op_count
);

    localparam int CW = $clog2(CALC_LAT + 1);

    state_t        state, state_nxt;
    logic          ptr;
    logic [1:0]    gnt;
    logic          gnt_id;
    logic          id_q;
    logic [CW-1:0] cnt;
    logic          take;

    rr_arb2 u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // gnt is only ever set for a valid requester, so any grant is a transfer
    assign take = (state == IDLE) && (|gnt);

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        calc_en   = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = gnt;
                if (|gnt)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                calc_en   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == CW'(1))
                    state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The calc_* registers double as the operand latch: loaded on the
    // transfer edge, driven during ISSUE and held afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            id_q      <= 1'b0;
            cnt       <= '0;
            calc_modo <= '0;
            calc_a    <= '0;
            calc_b    <= '0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            op_count  <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                calc_modo <= gnt_id ? req_modo1 : req_modo0;
                calc_a    <= gnt_id ? req_a1 : req_a0;
                calc_b    <= gnt_id ? req_b1 : req_b0;
                id_q      <= gnt_id;
            end
            if (state == ISSUE)
                cnt <= CW'(CALC_LAT);
            if (state == WAIT) begin
                cnt <= cnt - 1'b1;
                // cnt==1 is exactly CALC_LAT cycles after the calc_en cycle
                if (cnt == CW'(1)) begin
                    rsp_data <= calc_c;
                    rsp_id   <= id_q;
                end
            end
            if (state == RESP && rsp_ready) begin
                if (op_count != '1)
                    op_count <= op_count + 1'b1;
                ptr <= ~rsp_id;
            end
        end
    end

endmodule

// File: tb/tb_calc_scheduler.sv
// Testbench for calc_scheduler with a registered Calculadora model.
// Directed steps, scoreboard queue, immediate-assertion checks.
module tb_calc_scheduler;

    import calc_scheduler_pkg::*;

    localparam int W   = 8;
    localparam int LAT = 3;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_modo0, req_modo1;
    logic [W-1:0]  req_a0, req_b0, req_a1, req_b1;
    logic          calc_en;
    logic [1:0]    calc_modo;
    logic [W-1:0]  calc_a, calc_b, calc_c;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0]  rsp_data;
    logic [CW-1:0] op_count;

    int passed = 0;
    int total  = 0;
    int exp_cnt = 0;
    logic [W:0] sb[$];

    always #5 clk = ~clk;

    calc_scheduler #(
        .DATA_W   (W),
        .CALC_LAT (LAT),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_modo0 (req_modo0),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_modo1 (req_modo1),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .calc_en   (calc_en),
        .calc_modo (calc_modo),
        .calc_a    (calc_a),
        .calc_b    (calc_b),
        .calc_c    (calc_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .op_count  (op_count)
    );

    function automatic logic [W-1:0] calc_f(logic [1:0] m, logic [W-1:0] a, logic [W-1:0] b);
        case (m)
            MODO_0:  return a + b;
            MODO_1:  return a - b;
            MODO_2:  return a & b;
            default: return a | b;
        endcase
    endfunction

    // Calculadora model: result valid LAT cycles after the en cycle,
    // junk otherwise so a mistimed capture shows up.
    logic [W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= calc_en ? calc_f(calc_modo, calc_a, calc_b) : 8'hEE;
        for (int i = 1; i < LAT; i++)
            pipe[i] <= pipe[i-1];
    end
    assign calc_c = pipe[LAT-1];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(int id, logic [1:0] m, logic [W-1:0] a, logic [W-1:0] b);
        if (id == 0) begin
            req_modo0 = m; req_a0 = a; req_b0 = b;
        end else begin
            req_modo1 = m; req_a1 = a; req_b1 = b;
        end
        req_valid[id] = 1'b1;
    endtask

    // Returns at the negedge of the ISSUE cycle.
    task automatic await_accept(int id);
        int n;
        logic [1:0] g;
        logic [1:0] m;
        logic [W-1:0] a, b;
        n = 0;
        #1;
        while (!(|req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 20), 1);
        g = (id == 0) ? 2'b01 : 2'b10;
        chk("grant", 32'(req_ready), 32'(g));
        m = (id == 0) ? req_modo0 : req_modo1;
        a = (id == 0) ? req_a0 : req_a1;
        b = (id == 0) ? req_b0 : req_b1;
        sb.push_back({id[0], calc_f(m, a, b)});
        @(negedge clk);
        req_valid[id] = 1'b0;
        chk("issue_en", 32'(calc_en), 1);
        chk("issue_modo", 32'(calc_modo), 32'(m));
        chk("issue_a", 32'(calc_a), 32'(a));
        chk("issue_b", 32'(calc_b), 32'(b));
    endtask

    task automatic await_rsp(int hold);
        int n;
        int en;
        logic [W:0] e;
        logic [W-1:0] d0;
        n = 0;
        en = 0;
        do begin
            @(negedge clk);
            n++;
            if (calc_en) en++;
        end while (!rsp_valid && n < 20);
        chk("rsp_latency", 32'(n), 32'(LAT + 1));
        chk("no_extra_en", 32'(en), 0);
        d0 = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", 32'(rsp_data), 32'(d0));
            chk("hold_ready", 32'(req_ready), 0);
            chk("hold_en", 32'(calc_en), 0);
        end
        rsp_ready = 1'b1;
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk("rsp_id", 32'(rsp_id), 32'(e[W]));
        chk("rsp_data", 32'(rsp_data), 32'(e[W-1:0]));
        @(negedge clk);
        exp_cnt++;
        chk("op_count", 32'(op_count), 32'(exp_cnt));
        chk("rsp_done", 32'(rsp_valid), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0;
    endtask

    initial begin
        int nv;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_modo0 = '0; req_a0 = '0; req_b0 = '0;
        req_modo1 = '0; req_a1 = '0; req_b1 = '0;
        rsp_ready = 1'b1;

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_en", 32'(calc_en), 0);
        chk("rst_modo", 32'(calc_modo), 0);
        chk("rst_a", 32'(calc_a), 0);
        chk("rst_b", 32'(calc_b), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_data", 32'(rsp_data), 0);
        chk("rst_cnt", 32'(op_count), 0);

        // single requester 0
        drive(0, MODO_0, 8'h12, 8'h34);
        await_accept(0);
        await_rsp(0);

        // both valid after reset: 0, then 1, then 0 again
        do_reset();
        drive(0, MODO_0, 8'h10, 8'h20);
        drive(1, MODO_1, 8'h50, 8'h08);
        await_accept(0);
        await_rsp(0);
        await_accept(1);
        await_rsp(0);
        drive(0, MODO_2, 8'hF0, 8'h3C);
        drive(1, MODO_0, 8'h7F, 8'h01);
        await_accept(0);
        // consumer stalls while requester 1 waits
        rsp_ready = 1'b0;
        await_rsp(5);
        await_accept(1);
        await_rsp(0);

        // reset while waiting on the calculator
        drive(0, MODO_0, 8'h01, 8'h01);
        await_accept(0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_en", 32'(calc_en), 0);
        chk("abort_valid", 32'(rsp_valid), 0);
        chk("abort_cnt", 32'(op_count), 0);
        chk("abort_a", 32'(calc_a), 0);
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0;
        nv = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (rsp_valid) nv++;
        end
        chk("abort_no_rsp", 32'(nv), 0);

        // wraparound, sole requester 1, exact LAT capture
        drive(1, MODO_0, 8'hFF, 8'h02);
        await_accept(1);
        await_rsp(0);

        // MODO 11 forwarded untouched
        drive(0, MODO_3, 8'hA5, 8'h0F);
        await_accept(0);
        await_rsp(0);

        chk("sb_drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
